// File: rtl/receiver_wrapper.sv
// -----------------------------------------------------------------------------
// receiver_wrapper
//   UART receive path: a two-flop synchroniser and an 8N1 deserialiser (LSB
//   first) feeding a small distributed-RAM FIFO. The consumer drains the FIFO
//   with a valid/ready handshake. Frames that arrive while the FIFO is full are
//   dropped and raise the sticky overflow flag. Frames whose stop bit samples 0
//   are dropped and raise the sticky framing_error flag.
//
// Handshake: out is meaningful whenever valid is high. A byte is consumed on
//   every rising clk edge where valid && ready. While valid && !ready, out and
//   valid hold steady. ready is ignored while valid is low.
//
// Parameters
//   RECEIVER_PERIOD  clock cycles per serial bit (integer >= 4)
//   IN_BUFFER_WIDTH  FIFO pointer width; usable depth is 2**IN_BUFFER_WIDTH-1
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous reset, active low
//   in             in   serial RX line, idles high
//   out[7:0]       out  byte at the FIFO head
//   valid          out  FIFO non-empty
//   ready          in   consumer accepts out this cycle
//   overflow       out  sticky: a byte was dropped because the FIFO was full
//   framing_error  out  sticky: a frame was dropped for a bad stop bit
// -----------------------------------------------------------------------------
module receiver_wrapper #(
    parameter int RECEIVER_PERIOD = 868,
    parameter int IN_BUFFER_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic [7:0] out,
    output logic       valid,
    input  logic       ready,
    output logic       overflow,
    output logic       framing_error
);

    localparam int CW    = $clog2(RECEIVER_PERIOD);
    localparam int DEPTH = 1 << IN_BUFFER_WIDTH;

    // The counter is loaded with N-1 and counts down to 0, so the sample
    // lands exactly N cycles after the load.
    localparam logic [CW-1:0] HALF_LOAD = CW'(RECEIVER_PERIOD / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(RECEIVER_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IN_BUFFER_WIDTH-1:0] PTR_ONE = IN_BUFFER_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchroniser
    logic r_sync1;
    logic r_sync2;
    logic w_s;

    // Deserialiser
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          w_stop_sample;
    logic          w_stop_good;

    // FIFO
    logic [7:0]                 r_buf [DEPTH];
    logic [IN_BUFFER_WIDTH-1:0] r_in_ptr;
    logic [IN_BUFFER_WIDTH-1:0] r_out_ptr;
    logic [IN_BUFFER_WIDTH-1:0] w_in_ptr_inc;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;

    // Sticky flags
    logic r_overflow;
    logic r_framing_error;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser; flops reset to the idle line level.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    // -------------------------------------------------------------------------
    // Deserialiser FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Deserialiser FSM: next state and stop-bit outcome
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_stop_sample = 1'b0;
        w_stop_good   = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = HALF_LOAD;
                end
            end

            START: begin
                if (r_cnt == CNT_ZERO) begin
                    // A line that is high again at mid start bit was a glitch.
                    if (w_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = FULL_LOAD;
                        w_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            DATA: begin
                if (r_cnt == CNT_ZERO) begin
                    // LSB arrives first, so shift right and insert at the top.
                    w_shift_nxt = {w_s, r_shift[7:1]};
                    w_cnt_nxt   = FULL_LOAD;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            STOP: begin
                if (r_cnt == CNT_ZERO) begin
                    // Back to IDLE mid stop bit so a following start edge is
                    // never missed.
                    w_stop_sample = 1'b1;
                    w_stop_good   = w_s;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO. One slot is sacrificed so that full and empty are distinguishable
    // from the pointers alone. full is taken from the current pointers, so a
    // pop in the same cycle does not make room for a push.
    // -------------------------------------------------------------------------
    assign w_in_ptr_inc = r_in_ptr + PTR_ONE;
    assign w_full       = (w_in_ptr_inc == r_out_ptr);
    assign w_empty      = (r_in_ptr == r_out_ptr);
    assign w_push       = w_stop_sample && w_stop_good && !w_full;
    assign w_pop        = !w_empty && ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_in_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ptr  <= '0;
            r_out_ptr <= '0;
        end else begin
            if (w_push) begin
                r_in_ptr <= w_in_ptr_inc;
            end
            if (w_pop) begin
                r_out_ptr <= r_out_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow      <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            if (w_stop_sample && w_stop_good && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_stop_sample && !w_stop_good) begin
                r_framing_error <= 1'b1;
            end
        end
    end

    assign out           = r_buf[r_out_ptr];
    assign valid         = !w_empty;
    assign overflow      = r_overflow;
    assign framing_error = r_framing_error;

endmodule

// File: tb/tb_receiver_wrapper.sv
module tb_receiver_wrapper;

  localparam int P      = 16;
  localparam int W      = 2;
  localparam int USABLE = (1 << W) - 1;
  // posedges from driving the start bit (at a negedge) to the stop-sample
  // edge: 2 synchroniser edges, detection cycle, half a bit, 9 full bits
  localparam int LAT    = 2 + 1 + P / 2 + 9 * P;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_line = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] out;
  logic       valid;
  logic       overflow;
  logic       framing_error;

  receiver_wrapper #(
    .RECEIVER_PERIOD(P),
    .IN_BUFFER_WIDTH(W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in_line),
    .out          (out),
    .valid        (valid),
    .ready        (ready),
    .overflow     (overflow),
    .framing_error(framing_error)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int         edge_no;
    logic [7:0] data;
    bit         good;
  } frame_ev_t;

  frame_ev_t  ev_q[$];
  logic [7:0] exp_q[$];
  bit         exp_ov = 1'b0;
  bit         exp_fe = 1'b0;
  bit         model_full;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a byte queue with USABLE slots. On each edge, fullness
  // is judged first, then the consumer takes the head, then the frame whose
  // stop sample falls on this edge is resolved.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      ev_q.delete();
      exp_ov = 1'b0;
      exp_fe = 1'b0;
    end else begin
      model_full = (exp_q.size() == USABLE);
      if (exp_q.size() != 0 && ready) void'(exp_q.pop_front());
      if (ev_q.size() != 0 && ev_q[0].edge_no == cyc + 1) begin
        if (!ev_q[0].good) exp_fe = 1'b1;
        else if (model_full) exp_ov = 1'b1;
        else exp_q.push_back(ev_q[0].data);
        void'(ev_q.pop_front());
      end
    end
  end

  // Handshake monitor (pre-edge values)
  int         pop_count = 0;
  logic [7:0] last_pop = 8'h00;
  always @(posedge clk) begin
    if (rst_n && valid && ready) begin
      pop_count++;
      last_pop = out;
    end
  end

  // Per-cycle output check, away from the active edge
  int valid_cycles = 0;
  int first_valid_cyc = -1;
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    check("valid", valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out", out, exp_q[0]);
    check("overflow", overflow, exp_ov);
    check("framing_error", framing_error, exp_fe);
    if (valid) valid_cycles++;
    if (valid && !prev_valid) first_valid_cyc = cyc;
    prev_valid = valid;
  end

  // ---------------------------------------------------------------- drivers
  int last_stop_edge = 0;

  // Called at a negedge; returns at a negedge.
  task automatic send_frame(input logic [7:0] b, input bit good, input int idle);
    frame_ev_t ev;
    in_line = 1'b0;
    last_stop_edge = cyc + LAT;
    ev.edge_no = last_stop_edge;
    ev.data = b;
    ev.good = good;
    ev_q.push_back(ev);
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in_line = b[i];
      repeat (P) @(negedge clk);
    end
    in_line = good;
    repeat (P) @(negedge clk);
    in_line = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  task automatic glitch(input int low_cycles);
    in_line = 1'b0;
    repeat (low_cycles) @(negedge clk);
    in_line = 1'b1;
    repeat (P + 4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_line = 1'b1;
    ready = 1'b0;
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_framing_error", framing_error, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  int base_pops;
  int base_valid;
  int t1_stop;
  bit rand_done;
  int rdy_pct;
  logic [7:0] partial_b;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid", valid, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_framing_error", framing_error, 1'b0);

    // 1: single byte, consumer always ready
    ready = 1'b1;
    base_valid = valid_cycles;
    base_pops = pop_count;
    send_frame(8'h55, 1'b1, 0);
    t1_stop = last_stop_edge;
    repeat (P) @(negedge clk);
    check("t1_valid_latency", first_valid_cyc, t1_stop);
    check("t1_valid_cycles", valid_cycles - base_valid, 1);
    check("t1_pops", pop_count - base_pops, 1);
    check("t1_byte", last_pop, 8'h55);
    check("t1_flags", {overflow, framing_error}, 2'b00);

    // 2: short low pulse is rejected, next frame fine
    base_valid = valid_cycles;
    glitch(4);
    check("t2_no_valid", valid_cycles - base_valid, 0);
    check("t2_flags", {overflow, framing_error}, 2'b00);
    base_pops = pop_count;
    send_frame(8'hC3, 1'b1, 0);
    repeat (P) @(negedge clk);
    check("t2_pops", pop_count - base_pops, 1);
    check("t2_byte", last_pop, 8'hC3);

    // 3: overflow with consumer stalled
    do_reset();
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    send_frame(8'h03, 1'b1, 0);
    send_frame(8'h04, 1'b1, 0);
    repeat (4) @(negedge clk);
    check("t3_overflow", overflow, 1'b1);
    check("t3_valid", valid, 1'b1);
    check("t3_head", out, 8'h01);
    base_pops = pop_count;
    ready = 1'b1;
    check("t3_pop0", out, 8'h01);
    @(negedge clk);
    check("t3_pop1", out, 8'h02);
    @(negedge clk);
    check("t3_pop2", out, 8'h03);
    @(negedge clk);
    check("t3_empty", valid, 1'b0);
    ready = 1'b0;
    check("t3_pops", pop_count - base_pops, 3);

    // 4: bad stop bit, then a good frame
    do_reset();
    ready = 1'b1;
    base_pops = pop_count;
    send_frame(8'hA5, 1'b0, 2 * P);
    check("t4_fe", framing_error, 1'b1);
    check("t4_no_pop", pop_count - base_pops, 0);
    send_frame(8'h5A, 1'b1, 0);
    repeat (P) @(negedge clk);
    check("t4_pops", pop_count - base_pops, 1);
    check("t4_byte", last_pop, 8'h5A);
    check("t4_fe_sticky", framing_error, 1'b1);

    // 5: full FIFO, pop on exactly the stop-sample cycle of a 4th byte
    do_reset();
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    send_frame(8'h33, 1'b1, 0);
    base_pops = pop_count;
    fork
      send_frame(8'h44, 1'b1, 0);
      begin
        #1;
        wait (cyc == last_stop_edge - 1);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check("t5_overflow", overflow, 1'b1);
    check("t5_one_pop", pop_count - base_pops, 1);
    check("t5_head", out, 8'h22);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    check("t5_pops", pop_count - base_pops, 3);
    check("t5_last", last_pop, 8'h33);
    check("t5_empty", valid, 1'b0);

    // 6: reset in the middle of a frame with bytes buffered and a flag set
    do_reset();
    send_frame(8'hA5, 1'b0, 2 * P);
    send_frame(8'h61, 1'b1, 0);
    send_frame(8'h62, 1'b1, 0);
    partial_b = 8'h99;
    in_line = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_line = partial_b[i];
      repeat (P) @(negedge clk);
    end
    in_line = partial_b[3];
    repeat (P / 2) @(negedge clk);
    check("t6_pre_valid", valid, 1'b1);
    check("t6_pre_fe", framing_error, 1'b1);
    #2 rst_n = 1'b0;
    in_line = 1'b1;
    #1;
    check("t6_rst_valid", valid, 1'b0);
    check("t6_rst_overflow", overflow, 1'b0);
    check("t6_rst_fe", framing_error, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    ready = 1'b1;
    base_pops = pop_count;
    send_frame(8'h7E, 1'b1, 0);
    repeat (P) @(negedge clk);
    check("t6_pops", pop_count - base_pops, 1);
    check("t6_byte", last_pop, 8'h7E);

    // Random traffic: slow consumer first (forces overflow), then a fast one
    do_reset();
    rand_done = 1'b0;
    rdy_pct = 2;
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          int kind;
          if (f == 15) rdy_pct = 60;
          kind = $urandom_range(0, 9);
          if (kind == 0) glitch($urandom_range(1, P / 2 - 1));
          else if (kind == 1) send_frame(8'($urandom_range(0, 255)), 1'b0, 2 * P);
          else send_frame(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 3));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          ready = ($urandom_range(0, 99) < rdy_pct);
        end
      end
    join
    ready = 1'b1;
    repeat (P) @(negedge clk);
    check("rand_drained", valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receiver_wrapper.md
Name: receiver_wrapper

Overview:
- UART receive path: on-board serial deserialiser plus a small distributed-RAM FIFO that decouples incoming bytes from a consumer using a valid/ready handshake.
- Mirror of the buffered transmit path; sits between the RX pin and the core's input-byte consumer.
- Drops bytes, with sticky error flags, on FIFO overflow or a bad stop bit.

Parameters:
- RECEIVER_PERIOD, 868, clock cycles per bit; must be an integer ≥ 4.
- IN_BUFFER_WIDTH, 4, FIFO pointer width; usable depth is 2**IN_BUFFER_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in  input  1  serial RX line; idles at 1; 8N1, LSB first.
- out  output  8  byte at the FIFO head.
- valid  output  1  FIFO non-empty; out is meaningful.
- ready  input  1  consumer accepts out this cycle.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- framing_error  output  1  sticky: a frame was dropped because its stop bit sampled 0.

Behaviour:
- Reset (async assert on rst_n=0, sync release): FSM=IDLE; bit counter and period counter = 0; both FIFO pointers = 0; valid=0; overflow=0; framing_error=0; synchroniser flops = 1. out is don't-care while valid=0.
- Synchroniser:
  - in passes through 2 flops; the FSM sees only the synchronised value s.
  - Detection cycle D = first cycle in IDLE with s=0.
- FSM states:
  - IDLE: on s=0, go to START and load the period counter.
  - START: at D+RECEIVER_PERIOD/2 (integer division), sample s. If s=1 (glitch), return to IDLE with no side effects. If s=0, go to DATA with bit index 0.
  - DATA: data bit i is sampled at D+RECEIVER_PERIOD/2+(i+1)*RECEIVER_PERIOD and shifted in LSB first. After i=7, go to STOP.
  - STOP: sample at D+RECEIVER_PERIOD/2+9*RECEIVER_PERIOD. Return to IDLE in the same cycle, i.e. mid stop bit, so back-to-back frames are received.
- Stop-bit outcome:
  - s=1: push the byte into the FIFO.
  - s=0: drop the byte and set framing_error.
- Period counter width is $clog2(RECEIVER_PERIOD); no other arithmetic width concerns.
- FIFO:
  - Buffer array of 2**IN_BUFFER_WIDTH x 8, distributed RAM.
  - Pointers in_ptr and out_ptr, each IN_BUFFER_WIDTH bits, wrap naturally modulo 2**IN_BUFFER_WIDTH.
  - full = (in_ptr+1 == out_ptr); empty = (in_ptr == out_ptr).
  - valid = !empty; out = buffer[out_ptr], read combinationally.
  - Pop when valid && ready: out_ptr increments.
  - Push when the stop sample is good and !full: write buffer[in_ptr], in_ptr increments.
  - Push latency: the byte is visible on out/valid the cycle after the stop-sample cycle, when the FIFO was empty.
  - Push with full=1: byte discarded, overflow set. full is evaluated from the pointers before any same-cycle pop, so a simultaneous pop does not rescue the push.
  - Push and pop in the same cycle when not full: both take effect; occupancy unchanged.
  - ready while valid=0: ignored.
  - valid/out stay stable while valid && !ready; only a pop changes out.
- Sticky flags clear only on reset.
- Reset mid-frame or mid-handshake: everything returns to reset values immediately and buffered bytes are lost. The next frame whose start edge follows reset release is received normally.

Test Plan:
1. RECEIVER_PERIOD=16, IN_BUFFER_WIDTH=2, ready=1; send 0x55 → valid high exactly 1 cycle, out=0x55, one cycle after stop sample (D+152); overflow=0, framing_error=0.
2. Drive in low for 4 cycles, then high → no START→DATA transition, valid stays 0, no flags; a following 0xC3 frame is received correctly.
3. ready=0; send 0x01,0x02,0x03,0x04 back-to-back → after frame 4, overflow=1 and valid=1 with out=0x01. Then ready=1 → pops 0x01,0x02,0x03 on consecutive cycles, then valid=0; 0x04 is never seen.
4. Send 0xA5 with stop bit driven 0 → no push, framing_error=1. Then send 0x5A valid frame → out=0x5A, framing_error remains 1.
5. FIFO full (3 bytes), ready=1 asserted on exactly the cycle a 4th stop sample succeeds → pop occurs, push dropped, overflow=1, occupancy becomes 2.
6. Pull rst_n low during DATA bit 3 with 2 bytes buffered → valid=0 and flags=0 immediately. After release, send 0x7E → single byte 0x7E delivered.
